// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue: sender FSM
// states, the UART byte width and the default queue depth.
package uart_pkg;

  localparam int UART_BYTE_W    = 8;
  localparam int UART_TXQ_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bus-side and serializer-side signals of the UART transmit queue.
// slave is the queue's view, master is the view of whoever drives it.
interface uart_tx_queue_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TXQ_DEPTH
);

  logic                   wr;
  logic [UART_BYTE_W-1:0] wdata;
  logic                   tx_status;
  logic                   tx_en;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;

  modport slave (
    input  wr, wdata, tx_status,
    output tx_en, tx_data, full, empty, level
  );

  modport master (
    output wr, wdata, tx_status,
    input  tx_en, tx_data, full, empty, level
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Byte storage for the transmit queue: DEPTH x 8 array, one write port,
// one registered read port. The array itself carries no reset; only the
// read register does, so the byte shown to the serializer resets to 0.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TXQ_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [UART_BYTE_W-1:0] rd_data
);

  logic [UART_BYTE_W-1:0] mem_reg [DEPTH];
  logic [UART_BYTE_W-1:0] rd_data_reg;

  // Write port: plain RAM write, no reset on the array.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  // Read port: read-before-write, so a pop and a push to the same slot
  // (full queue) returns the old head. Holds its value between pops.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)   rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem_reg[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/uart_tx_queue.sv
// UART transmit queue: circular byte buffer in front of a serializer,
// plus the sender FSM that pops one byte, pulses tx_en and waits for the
// serializer to go busy and then idle again.
// Optional feature: define UART_TXQ_OVF_EN to add the sticky overflow
// flag ovf and its clear input ovf_clr.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TXQ_DEPTH
) (
  input  logic CLK,
  input  logic Reset_n,
`ifdef UART_TXQ_OVF_EN
  input  logic ovf_clr,
  output logic ovf,
`endif
  uart_tx_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  tx_state_e     state_reg;
  tx_state_e     state_next;
  logic          pop;
  logic          push;
  logic          tx_en_next;
  logic          full_w;
  logic          empty_w;

  assign full_w  = (level_reg == LEVEL_FULL);
  assign empty_w = (level_reg == '0);

  // A push is accepted when there is room, or when a pop frees the head
  // slot on the same edge.
  assign push = bus.wr && (!full_w || pop);

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.wdata),
    .rd_en   (pop),
    .rd_addr (rd_ptr_reg),
    .rd_data (bus.tx_data)
  );

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Sender FSM state register.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Sender FSM next state, pop strobe and start pulse.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    tx_en_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_w && bus.tx_status) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_en_next = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.tx_status) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_status) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.tx_en = tx_en_next;
  assign bus.full  = full_w;
  assign bus.empty = empty_w;
  assign bus.level = level_reg;

`ifdef UART_TXQ_OVF_EN
  logic ovf_reg;
  logic wr_drop;

  // A write is dropped only when full and no pop makes room.
  assign wr_drop = bus.wr && !push;

  // Sticky overflow flag; a dropped write wins over a clear request.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)     ovf_reg <= 1'b0;
    else if (wr_drop) ovf_reg <= 1'b1;
    else if (ovf_clr) ovf_reg <= 1'b0;
  end

  assign ovf = ovf_reg;
`else
  // Overflowing writes are simply discarded; push already excludes them.
`endif

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of byte entries in the queue (power of two, 2..64).
REQ-002 The block SHALL have port CLK, input, 1, the single system clock; all state changes on posedge.
REQ-003 The block SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port wr, input, 1, push request from the bus write to the UART TX data register.
REQ-005 The block SHALL have port wdata, input, 8, byte to push.
REQ-006 The block SHALL have port tx_status, input, 1, serializer idle flag (1 = idle).
REQ-007 The block SHALL have port tx_en, output, 1, one-cycle start pulse to the serializer.
REQ-008 The block SHALL have port tx_data, output, 8, byte under transmission, held stable.
REQ-009 The block SHALL have ports full and empty, output, 1 each, queue status.
REQ-010 The block SHALL have port level, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-011 Storage SHALL be a circular buffer with rd/wr pointers wrapping modulo DEPTH.
REQ-012 A wr while not full SHALL store wdata and increment level on the same edge; a wr while full SHALL be dropped with no state change.
REQ-013 The sender FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-014 In IDLE with level>0 and tx_status=1, it SHALL pop the head into tx_data and go to LAUNCH.
REQ-015 In LAUNCH, tx_en SHALL be 1 for exactly that cycle; the next state SHALL be WAIT_BUSY.
REQ-016 In WAIT_BUSY it SHALL wait for tx_status=0, then go to WAIT_DONE.
REQ-017 In WAIT_DONE it SHALL wait for tx_status=1, then go to IDLE.
REQ-018 tx_data SHALL change only on a pop and SHALL stay stable from LAUNCH until the return to IDLE.
REQ-019 Latency from a push into an empty, idle queue to tx_en=1 SHALL be 2 cycles (push edge, then pop edge, then LAUNCH).
REQ-020 A simultaneous push and pop SHALL leave level unchanged; on a full queue the push SHALL succeed in the same cycle as the pop.
REQ-021 full SHALL equal (level==DEPTH) and empty SHALL equal (level==0), both combinational from level.
REQ-022 Back-to-back bytes SHALL be sent with no dropped or duplicated bytes, in FIFO order.

Reset
REQ-023 Reset_n=0 SHALL asynchronously set pointers=0, level=0, FSM=IDLE, tx_en=0, tx_data=8'h00, empty=1, full=0.
REQ-024 Reset mid-transmission SHALL discard all queued bytes; the serializer is reset by the same Reset_n.

Configuration
REQ-025 With UART_TXQ_OVF_EN defined, the block SHALL add output ovf (1 bit): sticky, set by a wr while full, cleared by input ovf_clr=1 or by reset, with set taking priority over clear.
REQ-026 Without UART_TXQ_OVF_EN, ports ovf and ovf_clr SHALL be absent and overflowing writes SHALL be silently dropped.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, the UART_BYTE_W=8 constant and the default queue depth.
REQ-028 Storage SHALL be sub-module uart_fifo_mem (DEPTH x 8, 1 write and 1 read port, no reset on the array); control and FSM SHALL stay in uart_tx_queue.

Verification
REQ-029 Push 8'hA5 into an empty queue with tx_status=1 -> tx_en pulses 1 cycle exactly 2 cycles later, tx_data=8'hA5, level returns to 0.
REQ-030 Push 8 bytes 0x01..0x08 in 8 cycles while tx_status=0 -> full=1, level=8; a 9th push of 0xFF is dropped; after release the serializer receives 0x01..0x08 in order.
REQ-031 On a full queue, push 0x55 on the same cycle as a pop -> level stays 8, and 0x55 is transmitted last.
REQ-032 Hold tx_status=1 (slow serializer) for 3 cycles after tx_en -> FSM stays in WAIT_BUSY and tx_data stays stable; no second tx_en occurs.
REQ-033 Assert Reset_n=0 in WAIT_DONE with level=3 -> all outputs return to their reset values immediately; no tx_en after release.
REQ-034 With UART_TXQ_OVF_EN, overflow one write -> ovf=1 until ovf_clr; ovf_clr asserted together with an overflowing write -> ovf stays 1.
